// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-word holding buffer feeding a shift register,
// one bit per enabled clock on x, back-to-back frames with no idle bit.
//
// state | meaning
// IDLE  | shifter empty; loads from hold on the next edge when hold_full
// SHIFT | x carries a frame bit; en consumes it, last bit reloads or returns to IDLE
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             out_bit;

  generate
    if (MSB_FIRST) begin : g_msb
      assign sh_next = {sh[WIDTH-2:0], 1'b0};
      assign out_bit = sh[WIDTH-1];
    end else begin : g_lsb
      assign sh_next = {1'b0, sh[WIDTH-1:1]};
      assign out_bit = sh[0];
    end
  endgenerate

  assign last_bit   = (cnt == LAST);
  assign in_ready   = !hold_full;
  assign x_valid    = (state == SHIFT);
  // sh is not cleared at frame end, so gate x to keep it 0 while idle
  assign x          = x_valid & out_bit;
  assign frame_done = x_valid & en & last_bit;
  assign busy       = x_valid | hold_full;

  // Accept only happens with hold empty and drain only with hold full, so the
  // two hold_full updates below never collide on one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      sh        <= '0;
      cnt       <= '0;
    end else begin
      if (in_valid && !hold_full) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_full) begin
            sh        <= hold;
            cnt       <= '0;
            hold_full <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            if (!last_bit) begin
              sh  <= sh_next;
              cnt <= cnt + CW'(1);
            end else if (hold_full) begin
              sh        <= hold;
              cnt       <= '0;
              hold_full <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first instance for framing, back-to-back,
// en gating and reset; an LSB-first instance for bit order.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid, en;
  logic       in_ready, x, x_valid, frame_done, busy;
  logic [7:0] in_data_l;
  logic       in_valid_l, en_l;
  logic       in_ready_l, x_l, x_valid_l, frame_done_l, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .en(en), .x(x), .x_valid(x_valid),
    .frame_done(frame_done), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .en(en_l), .x(x_l), .x_valid(x_valid_l),
    .frame_done(frame_done_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  w;
    logic [23:0] s;
    int          bi;
    int          c;

    reset = 1'b0; in_data = '0; in_valid = 1'b0; en = 1'b0;
    in_data_l = '0; in_valid_l = 1'b0; en_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_x_valid", x_valid, 0);
    check("rst_x", x, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk) reset = 1'b1;
    tick();

    // single frame A5, en held high
    w = 8'hA5;
    in_data = w; in_valid = 1'b1; en = 1'b1;
    tick();
    in_valid = 1'b0;
    check("s_acc_in_ready", in_ready, 0);
    check("s_acc_busy", busy, 1);
    check("s_acc_x_valid", x_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("s_x_valid", x_valid, 1);
      check("s_x", x, w[7-i]);
      check("s_frame_done", frame_done, (i == 7));
    end
    tick();
    check("s_end_x_valid", x_valid, 0);
    check("s_end_busy", busy, 0);
    check("s_end_x", x, 0);
    tick();

    // back-to-back A5, 0F, then 3C offered while hold is full
    s = 24'hA50F3C;
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    check("b_acc_in_ready", in_ready, 0);
    in_data = 8'h0F;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      if (i == 3) begin in_data = 8'h3C; in_valid = 1'b1; end
      if (i == 9) in_valid = 1'b0;
      check("b_x_valid", x_valid, 1);
      check("b_x", x, s[23-i]);
      check("b_frame_done", frame_done, (i == 7 || i == 15 || i == 23));
      check("b_in_ready", in_ready, (i == 0 || i == 8 || i >= 16));
    end
    tick();
    check("b_end_x_valid", x_valid, 0);
    check("b_end_busy", busy, 0);
    tick();

    // en pattern 1,0,0 repeating; en ignored while idle
    w = 8'hA5;
    en = 1'b0; in_data = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    bi = 0; c = 0;
    while (bi < 8 && c < 40) begin
      en = (c % 3 == 0);
      #1;
      check("e_x_valid", x_valid, 1);
      check("e_x", x, w[7-bi]);
      check("e_frame_done", frame_done, (en && bi == 7));
      if (en) bi++;
      c++;
      tick();
    end
    check("e_bits_done", bi, 8);
    check("e_end_x_valid", x_valid, 0);
    en = 1'b0;
    tick();

    // LSB-first instance: 01 -> 1,0,0,0,0,0,0,0
    w = 8'h01;
    en_l = 1'b1; in_data_l = w; in_valid_l = 1'b1;
    tick();
    in_valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("l_x_valid", x_valid_l, 1);
      check("l_x", x_l, w[i]);
      check("l_frame_done", frame_done_l, (i == 7));
    end
    tick();
    check("l_end_x_valid", x_valid_l, 0);
    check("l_end_busy", busy_l, 0);

    // reset mid-frame after third bit of A5, with 3C held
    w = 8'hA5;
    en = 1'b1; in_data = w; in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("r_pre_x", x, w[4]);
    check("r_pre_in_ready", in_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("r_x", x, 0);
    check("r_x_valid", x_valid, 0);
    check("r_busy", busy, 0);
    check("r_in_ready", in_ready, 1);
    check("r_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("r_post_x_valid", x_valid, 0);
      check("r_post_busy", busy, 0);
    end
    w = 8'hC3;
    in_data = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("r_new_x_valid", x_valid, 1);
    check("r_new_x", x, w[7]);
    repeat (10) tick();
    check("r_new_end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
